// File: rtl/noc_pkt_pkg.sv
// Packet layout and helpers shared by the NoC memory node.
// A packet is {type[1:0], dest, src, payload}, with the payload in the LSBs.
package noc_pkt_pkg;
    localparam int PKT_NODE_W = 5;
    localparam int PKT_DW     = 8;
    localparam int PKT_WIDTH  = 2 + 2*PKT_NODE_W + PKT_DW;
    localparam int TYPE_LSB   = PKT_WIDTH - 2;
    localparam int DEST_LSB   = PKT_NODE_W + PKT_DW;
    localparam int SRC_LSB    = PKT_DW;

    typedef enum logic [1:0] {
        PSUM    = 2'd0,
        IFMAP   = 2'd1,
        FILTER  = 2'd2,
        ILLEGAL = 2'd3
    } pkt_type_e;

    function automatic pkt_type_e pkt_type(input logic [PKT_WIDTH-1:0] p);
        return pkt_type_e'(p[TYPE_LSB +: 2]);
    endfunction

    function automatic logic [PKT_NODE_W-1:0] pkt_src(input logic [PKT_WIDTH-1:0] p);
        return p[SRC_LSB +: PKT_NODE_W];
    endfunction

    function automatic logic [PKT_DW-1:0] pkt_payload(input logic [PKT_WIDTH-1:0] p);
        return p[PKT_DW-1:0];
    endfunction

    function automatic logic [PKT_WIDTH-1:0] pkt_pack(input pkt_type_e t,
                                                       input logic [PKT_NODE_W-1:0] dest,
                                                       input logic [PKT_NODE_W-1:0] src,
                                                       input logic [PKT_DW-1:0] data);
        return {t, dest, src, data};
    endfunction
endpackage

// File: rtl/mem_req_fifo.sv
// Request queue in front of the serve FSM.
// When the queue is full, it still accepts a push in a cycle that also pops.
module mem_req_fifo #(
    parameter int W     = 20,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);
    localparam int PW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wp, rp;
    logic [PW:0]   cnt;
    logic          push, pop;

    assign out_valid = (cnt != '0);
    assign in_ready  = (cnt != (PW+1)'(DEPTH)) || out_ready;
    assign out_data  = mem[rp];
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wp  <= '0;
            rp  <= '0;
            cnt <= '0;
        end else begin
            if (push) wp <= wp + PW'(1);
            if (pop)  rp <= rp + PW'(1);
            case ({push, pop})
                2'b10:   cnt <= cnt + (PW+1)'(1);
                2'b01:   cnt <= cnt - (PW+1)'(1);
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wp] <= in_data;
    end
endmodule

// File: rtl/noc_mem_server.sv
// NoC memory node: serves filter and ifmap reads from the router and collects
// psum packets into a result buffer, which is read back through a side port.
module noc_mem_server
    import noc_pkt_pkg::*;
#(
    parameter int NODE_W       = PKT_NODE_W,
    parameter int DW           = PKT_DW,
    parameter int PKT_W        = 2 + 2*NODE_W + DW,
    parameter int FILTER_DEPTH = 9,
    parameter int IFMAP_DEPTH  = 25,
    parameter int RESULT_NUM   = 9,
    parameter int AW           = 8,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NODE_W-1:0] my_index,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic              wr_sel,
    input  logic [AW-1:0]     wr_addr,
    input  logic [DW-1:0]     wr_data,
    input  logic              pkt_in_valid,
    output logic              pkt_in_ready,
    input  logic [PKT_W-1:0]  pkt_in,
    output logic              pkt_out_valid,
    input  logic              pkt_out_ready,
    output logic [PKT_W-1:0]  pkt_out,
    input  logic              start,
    input  logic              rd_en,
    input  logic [AW-1:0]     rd_addr,
    output logic [DW-1:0]     rd_data,
    output logic              done,
    output logic              err
);
    localparam int FI_W = $clog2(FILTER_DEPTH);
    localparam int MI_W = $clog2(IFMAP_DEPTH);
    localparam int RI_W = $clog2(RESULT_NUM);

    typedef enum logic [1:0] {S_IDLE, S_EXEC, S_RESP} state_e;

    logic [DW-1:0]    filt_mem [FILTER_DEPTH];
    logic [DW-1:0]    map_mem  [IFMAP_DEPTH];
    logic [DW-1:0]    res_mem  [RESULT_NUM];
    state_e           state, state_n;
    logic             head_v, pop, filt_ld, map_ld;
    logic [PKT_W-1:0] head;
    pkt_type_e        head_t;
    logic [AW-1:0]    head_addr, ptr;
    logic [DW-1:0]    rd_word;
    logic             bad_addr, exec_rd, psum_exec, res_we, set_err, wr_en;
    logic             unused_dest;

    mem_req_fifo #(.W(PKT_W), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk(clk), .rst_n(rst_n),
        .in_valid(pkt_in_valid), .in_ready(pkt_in_ready), .in_data(pkt_in),
        .out_valid(head_v), .out_ready(pop), .out_data(head)
    );

    assign head_t        = pkt_type(head);
    assign head_addr     = AW'(pkt_payload(head));
    assign unused_dest   = ^head[DEST_LSB +: NODE_W];
    assign pkt_out_valid = (state == S_RESP);
    assign wr_en         = wr_valid && wr_ready;
    assign exec_rd       = (state == S_EXEC) && (head_t != PSUM);
    assign psum_exec     = (state == S_EXEC) && (head_t == PSUM);
    // start wins over a psum landing in the same cycle; that psum is lost and flagged
    assign res_we        = rst_n && psum_exec && !start && (ptr < AW'(RESULT_NUM));
    assign set_err       = ((state == S_IDLE) && head_v && (head_t == ILLEGAL))
                         || (exec_rd && bad_addr) || (psum_exec && !res_we);

    always_comb begin
        rd_word  = '0;
        bad_addr = 1'b0;
        if (head_t == FILTER) begin
            if (head_addr < AW'(FILTER_DEPTH)) rd_word = filt_mem[head_addr[FI_W-1:0]];
            else                               bad_addr = 1'b1;
        end else begin
            if (head_addr < AW'(IFMAP_DEPTH))  rd_word = map_mem[head_addr[MI_W-1:0]];
            else                               bad_addr = 1'b1;
        end
    end

    always_comb begin
        state_n = state;
        pop     = 1'b0;
        case (state)
            S_IDLE: if (head_v) begin
                if (head_t == ILLEGAL)                             pop = 1'b1;
                else if (head_t == PSUM || (filt_ld && map_ld))   state_n = S_EXEC;
            end
            S_EXEC: begin
                pop     = 1'b1;
                state_n = (head_t == PSUM) ? S_IDLE : S_RESP;
            end
            S_RESP: if (pkt_out_ready) state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            wr_ready <= 1'b0;
            pkt_out  <= '0;
            rd_data  <= '0;
            done     <= 1'b0;
            err      <= 1'b0;
            filt_ld  <= 1'b0;
            map_ld   <= 1'b0;
            ptr      <= '0;
        end else begin
            state    <= state_n;
            wr_ready <= 1'b1;
            if (exec_rd) pkt_out <= pkt_pack(head_t, pkt_src(head), my_index, rd_word);
            if (set_err) err <= 1'b1;
            if (wr_en && !wr_sel && wr_addr == AW'(FILTER_DEPTH-1)) filt_ld <= 1'b1;
            if (wr_en &&  wr_sel && wr_addr == AW'(IFMAP_DEPTH-1))  map_ld  <= 1'b1;
            if (start) begin
                ptr  <= '0;
                done <= 1'b0;
            end else if (res_we) begin
                ptr <= ptr + AW'(1);
                if (ptr == AW'(RESULT_NUM-1)) done <= 1'b1;
            end
            if (rd_en) rd_data <= (rd_addr < AW'(RESULT_NUM)) ? res_mem[rd_addr[RI_W-1:0]] : '0;
        end
    end

    // Buffer contents survive reset; only the control state is cleared
    always_ff @(posedge clk) begin
        if (wr_en && !wr_sel && wr_addr < AW'(FILTER_DEPTH)) filt_mem[wr_addr[FI_W-1:0]] <= wr_data;
        if (wr_en &&  wr_sel && wr_addr < AW'(IFMAP_DEPTH))  map_mem[wr_addr[MI_W-1:0]]  <= wr_data;
        if (res_we) res_mem[ptr[RI_W-1:0]] <= pkt_payload(head);
    end
endmodule
